uart_bus_master: RTL and testbench

//  Bus initiator for the UART peripheral's parallel register port (addr/ncs/nwe/nrst/data).

---
 rtl/uart_bus_master_if.sv | 30 +++
 rtl/uart_bus_master.sv | 165 ++++++++++++++++
 tb/tb_uart_bus_master.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_master_if.sv
// Command/response handshake plus the UART peripheral's parallel register port.
// The master modport is the bus initiator's view; slave is the peripheral/fabric side.
interface uart_bus_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] bus_addr;
    logic       bus_ncs;
    logic       bus_nwe;
    logic       bus_nrst;
    logic [7:0] bus_data_out;
    logic       bus_data_oe;
    logic [7:0] bus_data_in;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, bus_data_in,
        output cmd_ready, rsp_valid, rsp_rdata,
               bus_addr, bus_ncs, bus_nwe, bus_nrst, bus_data_out, bus_data_oe
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, bus_data_in,
        input  cmd_ready, rsp_valid, rsp_rdata,
               bus_addr, bus_ncs, bus_nwe, bus_nrst, bus_data_out, bus_data_oe
    );
endinterface

// File: rtl/uart_bus_master.sv
// Bus initiator for the UART register port: turns single-word commands into timed
// setup/strobe/hold read/write cycles and returns read data on a one-cycle response.
//
// state  | meaning
// RESET  | bus_nrst held low for RESET_CYCLES after rst releases
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | addr/nwe/wdata driven, ncs high
// STROBE | ncs low; read data sampled on the last cycle
// HOLD   | ncs high, addr/nwe/wdata still held
// DONE   | rsp_valid pulse, bus returns to idle levels
module uart_bus_master #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2,
    parameter int RESET_CYCLES  = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_bus_master_if.master  bus
);
    localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_B = (HOLD_CYCLES > RESET_CYCLES) ? HOLD_CYCLES : RESET_CYCLES;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RESET, S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [1:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       sample_q, sample_d;

    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]       bus_addr_q, bus_addr_d;
    logic             bus_ncs_q, bus_ncs_d;
    logic             bus_nwe_q, bus_nwe_d;
    logic             bus_nrst_q, bus_nrst_d;
    logic [7:0]       bus_data_out_q, bus_data_out_d;
    logic             bus_data_oe_q, bus_data_oe_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_RESET;
            cnt_q          <= '0;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            sample_q       <= '0;
            cmd_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            bus_addr_q     <= '0;
            bus_ncs_q      <= 1'b1;
            bus_nwe_q      <= 1'b1;
            bus_nrst_q     <= 1'b0;
            bus_data_out_q <= '0;
            bus_data_oe_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wr_q           <= wr_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            sample_q       <= sample_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            bus_addr_q     <= bus_addr_d;
            bus_ncs_q      <= bus_ncs_d;
            bus_nwe_q      <= bus_nwe_d;
            bus_nrst_q     <= bus_nrst_d;
            bus_data_out_q <= bus_data_out_d;
            bus_data_oe_q  <= bus_data_oe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sample_d = sample_q;
        unique case (state_q)
            // Reset leaves the counter at zero, so the release delay counts upward.
            S_RESET: begin
                if (cnt_q == RESET_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    wr_d    = bus.cmd_write;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LAST;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                    cnt_d   = STROBE_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    if (!wr_q) sample_d = bus.bus_data_in;
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_RESET;
        endcase
    end

    // Outputs are decoded from the next state so every bus pin comes straight from a flop.
    always_comb begin
        logic active;
        active         = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        cmd_ready_d    = (state_d == S_IDLE);
        rsp_valid_d    = (state_d == S_DONE);
        rsp_rdata_d    = rsp_rdata_q;
        if (state_d == S_DONE) rsp_rdata_d = wr_d ? 8'h00 : sample_d;
        bus_addr_d     = active ? addr_d : bus_addr_q;
        bus_ncs_d      = (state_d != S_STROBE);
        bus_nwe_d      = ~(active && wr_d);
        bus_nrst_d     = (state_d != S_RESET);
        bus_data_oe_d  = active && wr_d;
        bus_data_out_d = (active && wr_d) ? wdata_d : 8'h00;
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.bus_addr     = bus_addr_q;
    assign bus.bus_ncs      = bus_ncs_q;
    assign bus.bus_nwe      = bus_nwe_q;
    assign bus.bus_nrst     = bus_nrst_q;
    assign bus.bus_data_out = bus_data_out_q;
    assign bus.bus_data_oe  = bus_data_oe_q;
endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: random commands against a register-array model,
// with a simple peripheral that answers reads and stores writes seen on the bus.
module tb_uart_bus_master;
    localparam int SETUP  = 2;
    localparam int STROBE = 4;
    localparam int HOLD   = 2;
    localparam int LAT    = 1 + SETUP + STROBE + HOLD;

    typedef struct {
        bit         wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    int   rsp_cycs[$];

    logic [7:0] model_regs [4] = '{8'h02, 8'h3C, 8'h7E, 8'h91};
    logic [7:0] periph_mem [4] = '{8'h02, 8'h3C, 8'h7E, 8'h91};
    logic       ncs_prev = 1'b1;
    int         low_run = 0;
    logic [1:0] low_addr;
    logic       low_nwe;

    uart_bus_master_if bif();

    uart_bus_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral data pins only carry the register while ncs is low; garbage otherwise.
    assign bif.bus_data_in = bif.bus_ncs ? (periph_mem[bif.bus_addr] ^ 8'hA5)
                                         : periph_mem[bif.bus_addr];

    always @(negedge clk) begin
        if (!ncs_prev && bif.bus_ncs && bif.bus_nrst && !bif.bus_nwe)
            periph_mem[bif.bus_addr] <= bif.bus_data_out;
        ncs_prev <= bif.bus_ncs;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit w, input logic [1:0] a, input logic [7:0] d);
        exp_t e;
        e.wr    = w;
        e.addr  = a;
        e.wdata = d;
        e.rdata = w ? 8'h00 : model_regs[a];
        e.due   = cyc + LAT;
        if (w) model_regs[a] = d;
        sb.push_back(e);
    endtask

    // Scoreboard monitor and bus protocol checks, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (bif.rsp_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check("rsp_rdata", bif.rsp_rdata, e.rdata);
                check("rsp_latency", cyc, e.due);
                rsp_cycs.push_back(cyc);
            end
        end
        if (!rst && bif.bus_nrst) begin
            if (sb.size() > 0 && cyc == sb[0].due - (LAT - 1)) begin
                check("setup_nwe", bif.bus_nwe, !sb[0].wr);
                check("setup_oe", bif.bus_data_oe, sb[0].wr);
                check("setup_addr", bif.bus_addr, sb[0].addr);
                check("setup_ncs", bif.bus_ncs, 1);
            end
            if (!bif.bus_ncs) begin
                if (low_run == 0) begin
                    low_addr = bif.bus_addr;
                    low_nwe  = bif.bus_nwe;
                    if (sb.size() > 0) begin
                        check("ncs_fall_cycle", cyc, sb[0].due - (STROBE + HOLD));
                        check("strobe_addr", bif.bus_addr, sb[0].addr);
                        check("strobe_nwe", bif.bus_nwe, !sb[0].wr);
                        check("strobe_oe", bif.bus_data_oe, sb[0].wr);
                        if (sb[0].wr) check("strobe_wdata", bif.bus_data_out, sb[0].wdata);
                    end
                end else begin
                    check("strobe_addr_stable", bif.bus_addr, low_addr);
                    check("strobe_nwe_stable", bif.bus_nwe, low_nwe);
                end
                low_run++;
            end else if (low_run > 0) begin
                check("ncs_low_cycles", low_run, STROBE);
                low_run = 0;
            end
            if (bif.bus_data_oe) check("oe_only_on_write", bif.bus_nwe, 0);
            if (bif.cmd_ready || bif.rsp_valid) begin
                check("idle_oe", bif.bus_data_oe, 0);
                check("idle_nwe", bif.bus_nwe, 1);
                check("idle_ncs", bif.bus_ncs, 1);
                check("idle_data_out", bif.bus_data_out, 0);
            end
        end else begin
            low_run = 0;
        end
    end

    task automatic issue(input bit w, input logic [1:0] a, input logic [7:0] d);
        int n = 0;
        bif.cmd_valid = 1'b1;
        bif.cmd_write = w;
        bif.cmd_addr  = a;
        bif.cmd_wdata = d;
        while (!bif.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bif.cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 expected 1 within 200 cycles");
            bif.cmd_valid = 1'b0;
            return;
        end
        push_exp(w, a, d);
        @(negedge clk);
        bif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    task automatic reset_release_check();
        int n = 0;
        rst = 1'b0;
        while (!bif.bus_nrst && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("nrst_low_cycles", n, 16);
        check("cmd_ready_after_reset", bif.cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int accepted;
        bit w;
        logic [1:0] a;
        logic [7:0] d;

        bif.cmd_valid = 1'b0;
        bif.cmd_write = 1'b0;
        bif.cmd_addr  = 2'd0;
        bif.cmd_wdata = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ncs", bif.bus_ncs, 1);
        check("rst_nwe", bif.bus_nwe, 1);
        check("rst_nrst", bif.bus_nrst, 0);
        check("rst_addr", bif.bus_addr, 0);
        check("rst_data_out", bif.bus_data_out, 0);
        check("rst_oe", bif.bus_data_oe, 0);
        check("rst_cmd_ready", bif.cmd_ready, 0);
        check("rst_rsp_valid", bif.rsp_valid, 0);
        check("rst_rsp_rdata", bif.rsp_rdata, 0);
        reset_release_check();

        // Directed: write 0x41 to addr 1, read status (peripheral holds 0x02), read back addr 1.
        issue(1'b1, 2'd1, 8'h41);
        wait_idle();
        issue(1'b0, 2'd0, 8'h00);
        wait_idle();
        issue(1'b0, 2'd1, 8'h00);
        wait_idle();

        // Back-to-back reads with cmd_valid held high.
        rsp_cycs.delete();
        bif.cmd_valid = 1'b1;
        bif.cmd_write = 1'b0;
        bif.cmd_addr  = 2'd2;
        accepted = 0;
        n = 0;
        while (accepted < 3 && n < 200) begin
            if (bif.cmd_ready) begin
                push_exp(1'b0, 2'd2, 8'h00);
                accepted++;
            end
            @(negedge clk);
            n++;
        end
        bif.cmd_valid = 1'b0;
        check("b2b_accepts", accepted, 3);
        wait_idle();
        check("b2b_rsp_count", rsp_cycs.size(), 3);
        if (rsp_cycs.size() == 3) begin
            check("b2b_spacing_1", rsp_cycs[1] - rsp_cycs[0], LAT + 1);
            check("b2b_spacing_2", rsp_cycs[2] - rsp_cycs[1], LAT + 1);
        end

        // Reset in the middle of a read strobe.
        issue(1'b0, 2'd3, 8'h00);
        n = 0;
        while (bif.bus_ncs && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_strobe", bif.bus_ncs, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        check("abort_ncs", bif.bus_ncs, 1);
        check("abort_nrst", bif.bus_nrst, 0);
        check("abort_rsp_valid", bif.rsp_valid, 0);
        check("abort_oe", bif.bus_data_oe, 0);
        check("abort_cmd_ready", bif.cmd_ready, 0);
        repeat (2) @(negedge clk);
        reset_release_check();

        // Random traffic, with stray cmd_valid pulses while busy that must be ignored.
        repeat (40) begin
            w = 1'($urandom_range(0, 1));
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(w, a, d);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                if (!bif.cmd_ready) begin
                    bif.cmd_valid = 1'b1;
                    bif.cmd_write = 1'($urandom_range(0, 1));
                    bif.cmd_addr  = 2'($urandom_range(0, 3));
                    bif.cmd_wdata = 8'($urandom);
                    @(negedge clk);
                    bif.cmd_valid = 1'b0;
                end
            end
        end
        wait_idle();

        for (int i = 0; i < 4; i++) issue(1'b0, 2'(i), 8'h00);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
